spi_slave_trx_char: RTL and testbench
=====================================

SPI_SLAVE_TRX_CHAR -- requirements
Module: spi_slave_trx_char

Interface
REQ-001 The block SHALL have one clock, S_SYSCLK; reset S_RESETN SHALL be asynchronous and active-low.
REQ-002 The block SHALL have the parameter CHAR_NBITS, default 16: maximum character width in bits.
REQ-003 S_SYSCLK  in  1  platform clock.
REQ-004 S_RESETN  in  1  asynchronous active-low reset.
REQ-005 S_ENABLE  in  1  block enable; low forces IDLE.
REQ-006 S_CPOL  in  1  SCK idle level.
REQ-007 S_CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-008 S_REV  in  1  0: MSB first; 1: LSB first.
REQ-009 S_CHAR_LEN  in  4  character length minus one (N = S_CHAR_LEN+1, 1..16).
REQ-010 S_SPI_SCK  in  1  SPI clock from the master.
REQ-011 S_SPI_CS_N  in  1  active-low chip select from the master.
REQ-012 S_SPI_MOSI  in  1  serial data from the master.
REQ-013 S_SPI_MISO  out  1  serial data to the master.
REQ-014 S_WCHAR  in  CHAR_NBITS  character to transmit, sampled at character start.
REQ-015 S_RCHAR  out  CHAR_NBITS  last complete received character, zero-extended above bit N-1.
REQ-016 S_CHAR_DONE  out  1  one-cycle pulse on character completion.
REQ-017 S_RCHAR_ACK  in  1  host acknowledges S_RCHAR (used only with the macro in REQ-036).
REQ-018 S_OVERRUN  out  1  sticky overrun flag.

Function
REQ-019 SCK, CS_N and MOSI SHALL each pass through a 2-flop synchronizer on S_SYSCLK; SCK edges SHALL be detected from synchronized stage 2 versus a stage-3 register.
REQ-020 The block SHALL operate correctly for SCK frequency at or below S_SYSCLK/8.
REQ-021 The leading edge SHALL be rising when S_CPOL=0 and falling when S_CPOL=1; the trailing edge SHALL be the opposite edge.
REQ-022 The FSM SHALL have two states: IDLE and SHIFT.
REQ-023 IDLE->SHIFT SHALL occur on synchronized CS_N low with S_ENABLE=1; S_WCHAR SHALL load into the TX shifter and the bit counter SHALL clear.
REQ-024 When S_CPHA=0, the first TX bit SHALL appear on S_SPI_MISO in the cycle of entry to SHIFT; each later bit SHALL change on a trailing edge.
REQ-025 When S_CPHA=1, each TX bit, including the first, SHALL change on a leading edge.
REQ-026 On each sampling edge, the synchronized MOSI SHALL shift into the RX shifter and the bit counter SHALL increment.
REQ-027 The bit order SHALL be bit N-1 first when S_REV=0 and bit 0 first when S_REV=1, for both TX and RX.
REQ-028 On the Nth sampling edge, S_RCHAR SHALL update and S_CHAR_DONE SHALL pulse in the following S_SYSCLK cycle; the pulse SHALL occur no more than 4 S_SYSCLK cycles after the SCK pin edge.
REQ-029 If CS_N stays low after the Nth sampling edge, the block SHALL remain in SHIFT, reload S_WCHAR and clear the bit counter, so back-to-back characters have no gap.
REQ-030 CS_N rising mid-character SHALL abort to IDLE with no S_CHAR_DONE, S_RCHAR unchanged, and partial data discarded.
REQ-031 S_ENABLE low SHALL force IDLE within one cycle; S_RCHAR SHALL hold its value.
REQ-032 S_SPI_MISO SHALL drive 1 whenever in IDLE.
REQ-033 SCK edges while in IDLE SHALL be ignored.
REQ-034 S_CHAR_LEN SHALL be latched at character start; changes mid-character SHALL have no effect.

Reset
REQ-035 On S_RESETN low, the block SHALL asynchronously enter IDLE, with S_SPI_MISO=1, S_RCHAR=0, S_CHAR_DONE=0, S_OVERRUN=0, shifters 0, bit counter 0 and synchronizer flops at idle values (CS_N=1, SCK=S_CPOL, MOSI=1).

Configuration
REQ-036 With the macro SPI_SLAVE_OVERRUN_EN defined, the block SHALL keep a pending flag: set on S_CHAR_DONE, cleared on S_RCHAR_ACK (ACK wins when simultaneous with DONE); S_CHAR_DONE while pending SHALL set S_OVERRUN, which SHALL clear only on S_ENABLE low or reset, and S_RCHAR SHALL still update.
REQ-037 With SPI_SLAVE_OVERRUN_EN undefined, S_OVERRUN SHALL be tied 0, S_RCHAR_ACK SHALL be ignored and the pending logic SHALL be absent.

Verification
REQ-038 Mode 0, N=8, S_REV=0, S_WCHAR=16'h00A5, master sends 8'h3C at SYSCLK/10 -> master receives 8'hA5; S_RCHAR=16'h003C; one S_CHAR_DONE pulse.
REQ-039 Modes 1, 2 and 3 each with N=16, S_WCHAR=16'h55AA, master sends 16'h1234 -> S_RCHAR=16'h1234 and master receives 16'h55AA in all three modes.
REQ-040 S_REV=1, N=4, master sends LSB-first 4'b0001 -> S_RCHAR=16'h0001; MISO first bit equals S_WCHAR[0].
REQ-041 CS_N held low for two 8-bit characters 8'h11 then 8'h22 with S_WCHAR changed between them -> two DONE pulses, S_RCHAR=8'h11 then 8'h22, and the second TX character equals the new S_WCHAR.
REQ-042 CS_N deasserted after 5 of 8 bits -> no DONE, S_RCHAR holds its prior value, MISO=1; the next full character is received correctly.
REQ-043 With SPI_SLAVE_OVERRUN_EN defined, two characters with no ACK -> S_OVERRUN=1; S_ENABLE low -> S_OVERRUN=0; with ACK after each character -> S_OVERRUN stays 0.

Source files
------------

// File: rtl/spi_slave_trx_char.sv
// SPI slave transceiver for one character of 1..16 bits, all four SPI modes, MSB/LSB first.
// Optional SPI_SLAVE_OVERRUN_EN adds a pending/overrun tracker driven by S_RCHAR_ACK.
module spi_slave_trx_char #(
  parameter int CHAR_NBITS = 16
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESETN,
  input  logic                  S_ENABLE,
  input  logic                  S_CPOL,
  input  logic                  S_CPHA,
  input  logic                  S_REV,
  input  logic [3:0]            S_CHAR_LEN,
  input  logic                  S_SPI_SCK,
  input  logic                  S_SPI_CS_N,
  input  logic                  S_SPI_MOSI,
  output logic                  S_SPI_MISO,
  input  logic [CHAR_NBITS-1:0] S_WCHAR,
  output logic [CHAR_NBITS-1:0] S_RCHAR,
  output logic                  S_CHAR_DONE,
  input  logic                  S_RCHAR_ACK,
  output logic                  S_OVERRUN
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_q, state_d;

  logic sck_p0, sck_p1, sck_p2;
  logic cs_p0, cs_p1;
  logic mosi_p0, mosi_p1;

  logic [CHAR_NBITS-1:0] tx_sh, rx_sh, rx_next, rchar_q;
  logic [4:0]            cnt_q;
  logic [3:0]            len_q;
  logic                  miso_q, done_q, head;
  logic                  load, sample, launch, finish, last_bit;
  logic                  sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, launch_edge;

  // Stage p0/p1: synchronizers; p2: SCK history for edge detection
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      sck_p0  <= S_CPOL;
      sck_p1  <= S_CPOL;
      sck_p2  <= S_CPOL;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      mosi_p0 <= 1'b1;
      mosi_p1 <= 1'b1;
    end else begin
      sck_p0  <= S_SPI_SCK;
      sck_p1  <= sck_p0;
      sck_p2  <= sck_p1;
      cs_p0   <= S_SPI_CS_N;
      cs_p1   <= cs_p0;
      mosi_p0 <= S_SPI_MOSI;
      mosi_p1 <= mosi_p0;
    end
  end

  assign sck_rise    = sck_p1 & ~sck_p2;
  assign sck_fall    = ~sck_p1 & sck_p2;
  assign lead_edge   = S_CPOL ? sck_fall : sck_rise;
  assign trail_edge  = S_CPOL ? sck_rise : sck_fall;
  assign sample_edge = S_CPHA ? trail_edge : lead_edge;
  assign launch_edge = S_CPHA ? lead_edge : trail_edge;

  assign last_bit = (cnt_q == {1'b0, len_q});
  assign head     = S_REV ? tx_sh[0] : tx_sh[len_q];

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sample  = 1'b0;
    launch  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (S_ENABLE && !cs_p1) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (!S_ENABLE || cs_p1) begin
          state_d = IDLE;
        end else begin
          sample = sample_edge;
          // In CPHA=0 the first bit is already on MISO, so the trailing edge
          // that follows a reload must not advance the shifter.
          launch = launch_edge && (S_CPHA || (cnt_q != 5'd0));
          if (sample_edge && last_bit) begin
            finish = 1'b1;
            load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (S_REV) begin
      rx_next = rx_sh;
      rx_next[cnt_q[3:0]] = mosi_p1;
    end else begin
      rx_next = {rx_sh[CHAR_NBITS-2:0], mosi_p1};
    end
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shifter stage: TX/RX shifters, bit counter, completion outputs
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      miso_q  <= 1'b1;
      rchar_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        rchar_q <= rx_next;
      end
      if (load) begin
        tx_sh <= S_WCHAR;
        rx_sh <= '0;
        cnt_q <= '0;
        len_q <= S_CHAR_LEN;
      end else begin
        if (sample) begin
          rx_sh <= rx_next;
          cnt_q <= cnt_q + 5'd1;
        end
        if (launch) begin
          tx_sh <= S_REV ? (tx_sh >> 1) : (tx_sh << 1);
          if (S_CPHA) begin
            miso_q <= head;
          end
        end
      end
      if (state_q == IDLE) begin
        miso_q <= 1'b1;
      end
    end
  end

  assign S_SPI_MISO  = (state_q == IDLE) ? 1'b1 : (S_CPHA ? miso_q : head);
  assign S_RCHAR     = rchar_q;
  assign S_CHAR_DONE = done_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic pending_q, overrun_q;

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!S_ENABLE) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (S_RCHAR_ACK) begin
        pending_q <= 1'b0;
      end else if (done_q) begin
        pending_q <= 1'b1;
      end
      if (done_q && pending_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign S_OVERRUN = overrun_q;
`else
  logic unused_ack;
  assign unused_ack = S_RCHAR_ACK;
  assign S_OVERRUN  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_trx_char.sv
// Randomized bench for spi_slave_trx_char: an SPI master model drives characters and a
// queue-based reference predicts what the master and the host side should see.
module tb_spi_slave_trx_char;

  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        rst_n, enable, cpol, cpha, rev;
  logic [3:0]  char_len;
  logic        sck, cs_n, mosi, miso;
  logic [15:0] wchar, rchar;
  logic        char_done, rchar_ack, overrun;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] rq[$];
  logic [15:0] w_arr[5];
  logic [15:0] m_arr[4];
  logic [15:0] last_rchar;

  always #5 clk = ~clk;

  spi_slave_trx_char #(.CHAR_NBITS(16)) dut (
    .S_SYSCLK   (clk),
    .S_RESETN   (rst_n),
    .S_ENABLE   (enable),
    .S_CPOL     (cpol),
    .S_CPHA     (cpha),
    .S_REV      (rev),
    .S_CHAR_LEN (char_len),
    .S_SPI_SCK  (sck),
    .S_SPI_CS_N (cs_n),
    .S_SPI_MOSI (mosi),
    .S_SPI_MISO (miso),
    .S_WCHAR    (wchar),
    .S_RCHAR    (rchar),
    .S_CHAR_DONE(char_done),
    .S_RCHAR_ACK(rchar_ack),
    .S_OVERRUN  (overrun)
  );

  always @(negedge clk) begin
    if (char_done) rq.push_back(rchar);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mask_of(input int n);
    logic [31:0] m32;
    m32 = (32'h1 << n) - 32'h1;
    return m32[15:0];
  endfunction

  // Master model: sends nsend bits of an n-bit character, collects MISO bits.
  task automatic xfer(input int n, input int nsend, input logic [15:0] mdata,
                      input logic [15:0] wnext, output logic [15:0] mrecv);
    mrecv = '0;
    for (int i = 0; i < nsend; i++) begin
      int idx;
      idx = rev ? i : n - 1 - i;
      if (!cpha) begin
        mosi = mdata[idx];
        #HALF;
        sck = ~cpol;
        mrecv[idx] = miso;
      end else begin
        sck  = ~cpol;
        mosi = mdata[idx];
      end
      if (i == 0) begin
        wchar = wnext;
        if (n >= 2) char_len = 4'($urandom);
      end
      if (i == n - 1) char_len = 4'(n - 1);
      #HALF;
      sck = cpol;
      if (cpha) begin
        mrecv[idx] = miso;
        #HALF;
      end
    end
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic r);
    cpol = pol;
    cpha = pha;
    rev  = r;
    sck  = pol;
    #100;
  endtask

  task automatic run_seq(input int n, input int k);
    logic [15:0] recv, mask;
    mask = mask_of(n);
    char_len = 4'(n - 1);
    wchar = w_arr[0];
    rq.delete();
    #40;
    cs_n = 1'b0;
    #60;
    for (int c = 0; c < k; c++) begin
      xfer(n, n, m_arr[c], w_arr[c+1], recv);
      chk("master_rx", {16'h0, recv}, {16'h0, w_arr[c] & mask});
    end
    #60;
    cs_n = 1'b1;
    #60;
    chk("done_cnt", rq.size(), k);
    for (int c = 0; c < k; c++) begin
      if (c < rq.size()) chk("rchar", {16'h0, rq[c]}, {16'h0, m_arr[c] & mask});
    end
    chk("miso_idle", {31'h0, miso}, 32'h1);
    last_rchar = m_arr[k-1] & mask;
  endtask

  task automatic randomize_arrays();
    for (int i = 0; i < 5; i++) w_arr[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) m_arr[i] = 16'($urandom);
  endtask

  initial begin
    logic [15:0] dummy;
    rst_n = 1'b0; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; rev = 1'b0;
    char_len = 4'd7; sck = 1'b0; cs_n = 1'b1; mosi = 1'b1;
    wchar = '0; rchar_ack = 1'b0;
    #30;
    chk("rst_miso", {31'h0, miso}, 32'h1);
    chk("rst_rchar", {16'h0, rchar}, 32'h0);
    chk("rst_done", {31'h0, char_done}, 32'h0);
    chk("rst_ovr", {31'h0, overrun}, 32'h0);
    #10 rst_n = 1'b1;
    #40;

    // mode 0, 8 bits, MSB first
    set_mode(1'b0, 1'b0, 1'b0);
    randomize_arrays();
    w_arr[0] = 16'h00A5; m_arr[0] = 16'h003C;
    run_seq(8, 1);

    // modes 1..3, 16 bits
    for (int md = 1; md < 4; md++) begin
      set_mode(md[1], md[0], 1'b0);
      randomize_arrays();
      w_arr[0] = 16'h55AA; m_arr[0] = 16'h1234;
      run_seq(16, 1);
    end

    // LSB first, 4 bits
    set_mode(1'b0, 1'b0, 1'b1);
    randomize_arrays();
    m_arr[0] = 16'h0001;
    run_seq(4, 1);

    // back-to-back characters with S_WCHAR changed in between
    set_mode(1'b0, 1'b0, 1'b0);
    randomize_arrays();
    m_arr[0] = 16'h0011; m_arr[1] = 16'h0022;
    run_seq(8, 2);

    // abort after 5 of 8 bits
    char_len = 4'd7;
    wchar = 16'($urandom);
    rq.delete();
    cs_n = 1'b0;
    #60;
    xfer(8, 5, 16'($urandom), 16'($urandom), dummy);
    #60;
    cs_n = 1'b1;
    #60;
    chk("abort_done", rq.size(), 0);
    chk("abort_rchar", {16'h0, rchar}, {16'h0, last_rchar});
    chk("abort_miso", {31'h0, miso}, 32'h1);
    randomize_arrays();
    run_seq(8, 1);

    // enable low mid-character
    rq.delete();
    cs_n = 1'b0;
    #60;
    xfer(8, 3, 16'($urandom), 16'($urandom), dummy);
    enable = 1'b0;
    #20;
    chk("dis_miso", {31'h0, miso}, 32'h1);
    chk("dis_rchar", {16'h0, rchar}, {16'h0, last_rchar});
    cs_n = 1'b1;
    #20;
    enable = 1'b1;
    #60;
    chk("dis_done", rq.size(), 0);

    // randomized modes, lengths and burst sizes
    for (int it = 0; it < 25; it++) begin
      set_mode(1'($urandom), 1'($urandom), 1'($urandom));
      randomize_arrays();
      run_seq(int'($urandom_range(1, 16)), int'($urandom_range(1, 3)));
    end

    set_mode(1'b0, 1'b0, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
    randomize_arrays();
    run_seq(8, 2);
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    enable = 1'b0;
    #20;
    enable = 1'b1;
    #20;
    chk("ovr_clr", {31'h0, overrun}, 32'h0);
    for (int r = 0; r < 2; r++) begin
      randomize_arrays();
      run_seq(8, 1);
      rchar_ack = 1'b1;
      #10;
      rchar_ack = 1'b0;
      #20;
    end
    chk("ovr_ack", {31'h0, overrun}, 32'h0);
`else
    randomize_arrays();
    run_seq(8, 2);
    chk("ovr_tied", {31'h0, overrun}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
